// File: rtl/vector_fu_if.sv
// Operand/result handshake bundle between the tile memory stage, vector_fu and the output stage.
interface vector_fu_if #(
    parameter int width      = 16,
    parameter int num_inputs = 4
);
    logic             on_off;
    logic             r_data_vld;
    logic [width-1:0] adder_inputs [2*num_inputs];
    logic [width-1:0] config_in;
    logic             in_ack;
    logic             busy;
    logic [width-1:0] out_data [num_inputs];
    logic             out_vld;
    logic             out_rdy;
    logic             op_err;

    modport master (
        output on_off, r_data_vld, adder_inputs, config_in, out_rdy,
        input  in_ack, busy, out_data, out_vld, op_err
    );

    modport slave (
        input  on_off, r_data_vld, adder_inputs, config_in, out_rdy,
        output in_ack, busy, out_data, out_vld, op_err
    );
endinterface

// File: rtl/vector_fu.sv
// Lane-wise vector functional unit: capture operands, execute one op, hold result under valid/ready.
// Optional build macro VECTOR_FU_SATURATE_EN enables signed saturation for ADD/SUB/RED via config_in[3].
module vector_fu #(
    parameter int width      = 16,
    parameter int num_inputs = 4
) (
    input  logic        clk,
    input  logic        reset,
    vector_fu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_e;

    localparam logic [width-1:0] MAX_VAL = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0] MIN_VAL = {1'b1, {(width-1){1'b0}}};

    state_e           state_q, state_d;
    logic [width-1:0] a_q [num_inputs];
    logic [width-1:0] a_d [num_inputs];
    logic [width-1:0] b_q [num_inputs];
    logic [width-1:0] b_d [num_inputs];
    logic [width-1:0] out_data_q [num_inputs];
    logic [width-1:0] out_data_d [num_inputs];
    logic [width-1:0] result [num_inputs];
    logic [width-1:0] acc;
    logic [2:0]       op_q, op_d;
    logic             sat_q, sat_d;
    logic             out_vld_q, out_vld_d;
    logic             op_err_q, op_err_d;
    logic             op_illegal;
    logic             capture;
    logic             unused_cfg;

    // Upper config bits are reserved; only op (and optionally the saturate bit) are decoded.
    assign unused_cfg = ^bus.config_in;

    function automatic logic [width-1:0] sat_add(input logic [width-1:0] x,
                                                 input logic [width-1:0] y);
        logic [width:0] s;
        s = {x[width-1], x} + {y[width-1], y};
        if (s[width] != s[width-1]) return s[width] ? MIN_VAL : MAX_VAL;
        return s[width-1:0];
    endfunction

    function automatic logic [width-1:0] sat_sub(input logic [width-1:0] x,
                                                 input logic [width-1:0] y);
        logic [width:0] s;
        s = {x[width-1], x} - {y[width-1], y};
        if (s[width] != s[width-1]) return s[width] ? MIN_VAL : MAX_VAL;
        return s[width-1:0];
    endfunction

    // Datapath: evaluated from the captured operands while in EXEC.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        result     = '{default: '0};
        acc        = '0;
        op_illegal = 1'b0;
        case (op_q)
            3'd0: for (int i = 0; i < num_inputs; i++)
                      result[i] = sat_q ? sat_add(a_q[i], b_q[i]) : a_q[i] + b_q[i];
            3'd1: for (int i = 0; i < num_inputs; i++)
                      result[i] = sat_q ? sat_sub(a_q[i], b_q[i]) : a_q[i] - b_q[i];
            3'd2: for (int i = 0; i < num_inputs; i++)
                      result[i] = a_q[i] * b_q[i];
            3'd3: for (int i = 0; i < num_inputs; i++)
                      result[i] = ($signed(a_q[i]) > $signed(b_q[i])) ? a_q[i] : b_q[i];
            3'd4: for (int i = 0; i < num_inputs; i++)
                      result[i] = ($signed(a_q[i]) < $signed(b_q[i])) ? a_q[i] : b_q[i];
            3'd5: begin
                for (int i = 0; i < num_inputs; i++) begin
                    if (sat_q) begin
                        acc = sat_add(acc, a_q[i]);
                        acc = sat_add(acc, b_q[i]);
                    end else begin
                        acc = acc + a_q[i] + b_q[i];
                    end
                end
                result[0] = acc;
            end
            default: op_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sat_d      = sat_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        op_err_d   = op_err_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.on_off && bus.r_data_vld) begin
                    capture = 1'b1;
                    for (int i = 0; i < num_inputs; i++) begin
                        a_d[i] = bus.adder_inputs[i];
                        b_d[i] = bus.adder_inputs[i+num_inputs];
                    end
                    op_d = bus.config_in[2:0];
`ifdef VECTOR_FU_SATURATE_EN
                    sat_d = bus.config_in[3];
`else
                    sat_d = 1'b0;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!bus.on_off) begin
                    state_d = IDLE;
                end else begin
                    out_data_d = result;
                    out_vld_d  = 1'b1;
                    op_err_d   = op_err_q | op_illegal;
                    state_d    = OUT;
                end
            end
            OUT: begin
                // A presented result is only released by the consumer, never by on_off.
                if (bus.out_rdy) begin
                    out_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q    <= IDLE;
            // NOTE: operand/result arrays are reset too; out_data must read 0 after reset.
            a_q        <= '{default: '0};
            b_q        <= '{default: '0};
            out_data_q <= '{default: '0};
            op_q       <= '0;
            sat_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_data_q <= out_data_d;
            op_q       <= op_d;
            sat_q      <= sat_d;
            out_vld_q  <= out_vld_d;
            op_err_q   <= op_err_d;
        end
    end

    // in_ack is combinational for the capture cycle; masked so it reads 0 while reset is held.
    assign bus.in_ack   = capture & reset;
    assign bus.busy     = (state_q != IDLE);
    assign bus.out_data = out_data_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.op_err   = op_err_q;
endmodule

// File: tb/tb_vector_fu.sv
// Self-checking bench for vector_fu: directed table, handshake corner sequences, randomized model check.
module tb_vector_fu;
    localparam int W = 16;
    localparam int N = 4;

    typedef logic [W-1:0]        word_t;
    typedef logic [N-1:0][W-1:0] lanes_t;

    typedef struct {
        string  name;
        lanes_t a;
        lanes_t b;
        word_t  cfg;
        lanes_t exp;
        int     hold;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    vector_fu_if #(.width(W), .num_inputs(N)) vif ();
    vector_fu #(.width(W), .num_inputs(N)) dut (.clk(clk), .reset(reset), .bus(vif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic lanes_t mk(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
        lanes_t r;
        r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
        return r;
    endfunction

    function automatic lanes_t got_lanes();
        lanes_t r;
        for (int i = 0; i < N; i++) r[i] = vif.out_data[i];
        return r;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint sx(input word_t w);
        return longint'($signed(w));
    endfunction

    // Reference: per-lane arithmetic on integers, wrapped or clamped afterwards.
    function automatic lanes_t model(input lanes_t a, input lanes_t b, input word_t cfg);
        lanes_t r;
        bit     sat;
        longint acc;
        r   = '0;
        sat = 1'b0;
`ifdef VECTOR_FU_SATURATE_EN
        sat = cfg[3];
`endif
        acc = 0;
        for (int i = 0; i < N; i++) begin
            case (cfg[2:0])
                3'd0: r[i] = word_t'(sat ? clamp(sx(a[i]) + sx(b[i])) : longint'(a[i]) + longint'(b[i]));
                3'd1: r[i] = word_t'(sat ? clamp(sx(a[i]) - sx(b[i])) : longint'(a[i]) - longint'(b[i]));
                3'd2: r[i] = word_t'(longint'(a[i]) * longint'(b[i]));
                3'd3: r[i] = (sx(a[i]) > sx(b[i])) ? a[i] : b[i];
                3'd4: r[i] = (sx(a[i]) < sx(b[i])) ? a[i] : b[i];
                3'd5: acc = sat ? clamp(clamp(acc + sx(a[i])) + sx(b[i])) : acc + longint'(a[i]) + longint'(b[i]);
                default: r[i] = '0;
            endcase
        end
        if (cfg[2:0] == 3'd5) r[0] = word_t'(acc);
        return r;
    endfunction

    task automatic drive(input lanes_t a, input lanes_t b, input word_t cfg);
        for (int i = 0; i < N; i++) begin
            vif.adder_inputs[i]   = a[i];
            vif.adder_inputs[i+N] = b[i];
        end
        vif.config_in = cfg;
    endtask

    // One full transaction: capture, EXEC, `hold` stalled cycles in OUT, then handshake.
    task automatic run_op(input string name, input lanes_t a, input lanes_t b, input word_t cfg,
                          input lanes_t exp, input int hold);
        drive(a, b, cfg);
        vif.r_data_vld = 1'b1;
        vif.out_rdy    = 1'b0;
        #1;
        check({name, "_in_ack"}, vif.in_ack, 1);
        step();
        vif.r_data_vld = 1'b0;
        check({name, "_exec_busy"}, vif.busy, 1);
        check({name, "_exec_vld"}, vif.out_vld, 0);
        step();
        check({name, "_out_vld"}, vif.out_vld, 1);
        check({name, "_data"}, got_lanes(), exp);
        for (int h = 0; h < hold; h++) begin
            step();
            check({name, "_hold_vld"}, vif.out_vld, 1);
            check({name, "_hold_data"}, got_lanes(), exp);
        end
        vif.out_rdy = 1'b1;
        step();
        vif.out_rdy = 1'b0;
        check({name, "_done_vld"}, vif.out_vld, 0);
        check({name, "_done_busy"}, vif.busy, 0);
    endtask

    vec_t   tbl [$];
    vec_t   v;
    lanes_t prev;
    lanes_t ra, rb, junk_a, junk_b;
    word_t  rcfg;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        vif.on_off     = 1'b0;
        vif.r_data_vld = 1'b0;
        vif.out_rdy    = 1'b0;
        drive('0, '0, '0);

        v = '{"add", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0000, mk(11, 22, 33, 44), 0};
        tbl.push_back(v);
        v = '{"sub", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0001, mk(16'hFFF7, 16'hFFEE, 16'hFFE5, 16'hFFDC), 0};
        tbl.push_back(v);
        v = '{"mul_bp", mk(3, 4, 5, 16'h100), mk(7, 8, 9, 16'h100), 16'h0002, mk(21, 32, 45, 0), 5};
        tbl.push_back(v);
        v = '{"max", mk(5, 16'hFFFF, 16'h8000, 7), mk(3, 1, 16'h7FFF, 7), 16'h0003, mk(5, 1, 16'h7FFF, 7), 1};
        tbl.push_back(v);
        v = '{"min", mk(5, 16'hFFFF, 16'h8000, 7), mk(3, 1, 16'h7FFF, 7), 16'h0004, mk(3, 16'hFFFF, 16'h8000, 7), 0};
        tbl.push_back(v);
        v = '{"red", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0005, mk(110, 0, 0, 0), 0};
        tbl.push_back(v);
        v = '{"add_rsvd", mk(16'hFFFF, 1, 2, 3), mk(1, 1, 1, 1), 16'hFFF0, mk(0, 2, 3, 4), 0};
        tbl.push_back(v);
`ifdef VECTOR_FU_SATURATE_EN
        v = '{"sub_sat", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0009, mk(16'hFFF7, 16'hFFEE, 16'hFFE5, 16'hFFDC), 0};
        tbl.push_back(v);
        v = '{"red_sat", mk(16'h7000, 16'h7000, 0, 0), mk(0, 0, 0, 0), 16'h000D, mk(16'h7FFF, 0, 0, 0), 0};
        tbl.push_back(v);
`endif

        // Reset state
        step();
        step();
        check("rst_out_vld", vif.out_vld, 0);
        check("rst_busy", vif.busy, 0);
        check("rst_in_ack", vif.in_ack, 0);
        check("rst_op_err", vif.op_err, 0);
        check("rst_out_data", got_lanes(), 0);
        reset = 1'b1;
        vif.on_off = 1'b1;
        step();

        foreach (tbl[k]) run_op(tbl[k].name, tbl[k].a, tbl[k].b, tbl[k].cfg, tbl[k].exp, tbl[k].hold);

        // Bundle held valid while busy is ignored; next capture lands the edge after the handshake.
        junk_a = mk(16'h1234, 16'h8001, 9, 16'hFFFE);
        junk_b = mk(16'h0F0F, 2, 16'h7FFF, 3);
        drive(mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0000);
        vif.r_data_vld = 1'b1;
        step();
        drive(junk_a, junk_b, 16'h0003);
        check("busy_ignore_exec", vif.in_ack, 0);
        step();
        check("busy_ignore_out", vif.in_ack, 0);
        check("b2b_first_data", got_lanes(), mk(11, 22, 33, 44));
        vif.out_rdy = 1'b1;
        step();
        vif.out_rdy = 1'b0;
        check("b2b_hs_vld", vif.out_vld, 0);
        check("b2b_idle_ack", vif.in_ack, 1);
        step();
        vif.r_data_vld = 1'b0;
        check("b2b_second_busy", vif.busy, 1);
        step();
        check("b2b_second_data", got_lanes(), model(junk_a, junk_b, 16'h0003));
        vif.out_rdy = 1'b1;
        step();
        vif.out_rdy = 1'b0;

        // Abort in EXEC leaves the previous result untouched.
        prev = mk(11, 22, 33, 44);
        run_op("pre_abort", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0000, prev, 0);
        drive(mk(100, 100, 100, 100), mk(1, 1, 1, 1), 16'h0000);
        vif.r_data_vld = 1'b1;
        step();
        vif.r_data_vld = 1'b0;
        vif.on_off     = 1'b0;
        step();
        check("abort_busy", vif.busy, 0);
        check("abort_vld", vif.out_vld, 0);
        check("abort_data", got_lanes(), prev);
        step();
        check("abort_vld_later", vif.out_vld, 0);
        vif.on_off = 1'b1;

        // Unsupported opcodes and sticky error flag.
        check("err_clear_before", vif.op_err, 0);
        run_op("op6", mk(5, 6, 7, 8), mk(1, 1, 1, 1), 16'h0006, '0, 0);
        check("err_set", vif.op_err, 1);
        run_op("add_after_err", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0000, mk(11, 22, 33, 44), 0);
        check("err_sticky", vif.op_err, 1);
        run_op("op7", mk(1, 1, 1, 1), mk(2, 2, 2, 2), 16'h0007, '0, 0);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = word_t'($urandom);
                rb[i] = word_t'($urandom);
            end
            rcfg = word_t'($urandom);
            if (r % 3 == 0) rcfg[2:0] = 3'($urandom_range(0, 5));
            run_op("rand", ra, rb, rcfg, model(ra, rb, rcfg), int'($urandom_range(0, 2)));
        end
        check("err_sticky_rand", vif.op_err, 1);

        // Reset while a result is presented.
        drive(mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0000);
        vif.r_data_vld = 1'b1;
        step();
        vif.r_data_vld = 1'b0;
        step();
        check("pre_reset_vld", vif.out_vld, 1);
        reset = 1'b0;
        step();
        check("midrst_vld", vif.out_vld, 0);
        check("midrst_busy", vif.busy, 0);
        check("midrst_data", got_lanes(), 0);
        check("midrst_op_err", vif.op_err, 0);
        check("midrst_in_ack", vif.in_ack, 0);
        reset = 1'b1;
        step();
        run_op("add_after_rst", mk(1, 2, 3, 4), mk(10, 20, 30, 40), 16'h0000, mk(11, 22, 33, 44), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vector_fu.md
Name: vector_fu

Overview:
- Vector functional unit in s_tile, directly downstream of the tile memory stage.
- Captures the operand bundle presented by memory: lanes 0..num_inputs-1 = vec1, lanes num_inputs..2*num_inputs-1 = vec2.
- Executes one lane-wise operation selected by the config word, then holds the registered result under a valid/ready handshake for the tile output stage.

Parameters:
- width, 16, datapath bit width per lane
- num_inputs, 4, lanes per vector; total operand lanes = 2*num_inputs

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset; state cleared on rising clk edge while reset==0
- on_off  input  1  enable from memory (on_off_vector_fu)
- r_data_vld  input  1  operand bundle and config valid
- adder_inputs  input  width x 2*num_inputs (unpacked)  operand lanes
- config_in  input  width  operation config
- in_ack  output  1  one-cycle pulse: operands captured
- busy  output  1  state != IDLE
- out_data  output  width x num_inputs (unpacked)  result lanes
- out_vld  output  1  result valid
- out_rdy  input  1  consumer ready
- op_err  output  1  sticky: unsupported opcode seen

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0, including out_data lanes and op_err.
- FSM states: IDLE, EXEC, OUT.
- IDLE -> EXEC
  - Condition: on_off && r_data_vld.
  - Action: register a[i]=adder_inputs[i], b[i]=adder_inputs[i+num_inputs], and op=config_in[2:0]; pulse in_ack for exactly that cycle.
- EXEC -> OUT
  - Next edge: compute and register out_data; out_vld=1.
  - Latency: out_vld is high 2 edges after the capture edge.
  - If on_off==0 during EXEC: abort to IDLE; out_vld never rises; out_data unchanged.
- OUT
  - Hold out_data and out_vld stable until out_rdy==1 at a posedge.
  - On that edge: out_vld=0, state=IDLE.
  - on_off is ignored in OUT; a valid result is never retracted.
- Back-to-back: a new capture cannot occur on the handshake edge. The earliest next capture is the following edge, so one issue per 3 cycles maximum.
- r_data_vld while busy: ignored, no in_ack.
- Opcodes (op), lane i, arithmetic modulo 2^width unless noted:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 MUL: low width bits of a*b
  - 011 MAX: signed max(a,b)
  - 100 MIN: signed min(a,b)
  - 101 RED: lane0 = sum over all i of (a[i]+b[i]) mod 2^width; other lanes 0
  - 110 and 111: result all zero; op_err set (sticky until reset)
- config_in[width-1:3]: reserved, ignored.
- Reset asserted in any state: return to IDLE next edge; out_vld drops with no handshake.

Optional Feature:
- Macro: VECTOR_FU_SATURATE_EN.
- Defined:
  - config_in[3]=1 makes ADD, SUB and RED use signed saturating arithmetic, clamping to 0x7FFF/0x8000 for width=16.
  - RED saturates at each accumulation step, lane order 0..num_inputs-1.
- Not defined: config_in[3] is ignored and all arithmetic wraps.

Test Plan:
- ADD: vec1={1,2,3,4}, vec2={10,20,30,40}, config=0x0001 gives op=SUB.
  - Use config=0x0000 for this case -> out_data={11,22,33,44}.
  - in_ack pulses at capture; out_vld rises 2 edges later.
- SUB wrap: vec1={1,2,3,4}, vec2={10,20,30,40}, config=0x0001 -> out_data={FFF7,FFEE,FFE5,FFDC}.
  - With VECTOR_FU_SATURATE_EN and config=0x0009: same values, since there is no overflow.
- Backpressure:
  - MUL, vec1={3,4,5,0x100}, vec2={7,8,9,0x100}; hold out_rdy=0 for 5 cycles -> out_data={21,32,45,0x0000} stable, out_vld stays high.
  - Then out_rdy=1 -> out_vld low next edge; busy low.
- RED: vec1={1,2,3,4}, vec2={10,20,30,40}, config=0x0005 -> out_data={110,0,0,0}.
  - SATURATE_EN, config=0x000D, vec1={0x7000,0x7000,0,0}, vec2=0 -> lane0=0x7FFF.
- Abort and error:
  - Drop on_off in EXEC -> no out_vld; return to IDLE.
  - Then op=110 -> zeros; op_err=1 stays set across later ops.
- Reset mid-OUT: assert reset=0 while out_vld=1 -> next edge all outputs 0, state IDLE.
  - Subsequent ADD works normally.
